if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: owns the architectural PC register and the F/D pipeline register. Each cycle it presents the PC to instruction memory and checks the fetch address for AdEL. It latches the instruction, PC, exception code and branch-delay flag into the D stage. It consumes the next-PC value produced by the D-stage next-PC logic and supplies that logic with D-stage instruction and PC+4.

---
 rtl/if_stage.sv | 96 +++++++++
 tb/tb_if_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: architectural PC register, fetch-address AdEL check,
// and the F/D pipeline register feeding the decode stage.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        redirect,
    input  logic        d_is_bj,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] f_pc,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc4,
    output logic [4:0]  d_exc,
    output logic        d_bd,
    output logic        d_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] dpc_q, dpc_d;
    logic [4:0]  exc_q, exc_d;
    logic        bd_q, bd_d;
    logic        valid_q, valid_d;

    logic        f_bad;
    logic [4:0]  f_exc;
    logic [31:0] f_instr;

    // Unsigned range compare; misaligned or out-of-window fetches raise AdEL.
    always_comb begin
        f_bad   = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
        f_exc   = f_bad ? EXC_ADEL : 5'd0;
        f_instr = f_bad ? '0 : imem_rdata;
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        dpc_d   = dpc_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        valid_d = valid_q;
        if (redirect) begin
            // Bubble keeps the target PC so an interrupt taken on it saves a usable EPC.
            pc_d    = npc;
            instr_d = '0;
            dpc_d   = npc;
            exc_d   = '0;
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = npc;
            instr_d = f_instr;
            dpc_d   = pc_q;
            exc_d   = f_exc;
            bd_d    = d_is_bj;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            dpc_q   <= RESET_PC;
            exc_q   <= '0;
            bd_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            dpc_q   <= dpc_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign f_pc      = pc_q;
    assign d_instr   = instr_q;
    assign d_pc      = dpc_q;
    assign d_pc4     = dpc_q + 32'd4;
    assign d_exc     = exc_q;
    assign d_bd      = bd_q;
    assign d_valid   = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized traffic, all
// checked against a cycle-level reference model of the fetch stage.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, d_is_bj;
    logic [31:0] npc, imem_addr, imem_rdata, f_pc, d_instr, d_pc, d_pc4;
    logic [4:0]  d_exc;
    logic        d_bd, d_valid;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_dpc;
    logic [4:0]  m_exc;
    logic        m_bd, m_valid;

    if_stage #(
        .RESET_PC (32'h0000_3000),
        .IM_LO    (32'h0000_3000),
        .IM_HI    (32'h0000_6FFC),
        .EXC_ADEL (5'd4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall      (stall),
        .redirect   (redirect),
        .d_is_bj    (d_is_bj),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .f_pc       (f_pc),
        .d_instr    (d_instr),
        .d_pc       (d_pc),
        .d_pc4      (d_pc4),
        .d_exc      (d_exc),
        .d_bd       (d_bd),
        .d_valid    (d_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_3000: return 32'h2408_0001;
            32'h0000_3004: return 32'h2409_0002;
            32'h0000_3008: return 32'h0000_0000;
            default:       return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Memory answers whatever address is presented, including illegal ones.
    always_comb imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    task automatic model_step(input logic r, input logic st, input logic rd,
                              input logic bj, input logic [31:0] n);
        if (r) begin
            m_pc = 32'h3000; m_instr = 0; m_dpc = 32'h3000;
            m_exc = 0; m_bd = 0; m_valid = 0;
        end else if (rd) begin
            m_pc = n; m_instr = 0; m_dpc = n;
            m_exc = 0; m_bd = 0; m_valid = 0;
        end else if (!st) begin
            m_instr = addr_bad(m_pc) ? 32'h0 : mem_word(m_pc);
            m_exc   = addr_bad(m_pc) ? 5'd4 : 5'd0;
            m_dpc   = m_pc;
            m_bd    = bj;
            m_valid = 1'b1;
            m_pc    = n;
        end
    endtask

    task automatic compare_all();
        check("f_pc",      f_pc,      m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("d_instr",   d_instr,   m_instr);
        check("d_pc",      d_pc,      m_dpc);
        check("d_pc4",     d_pc4,     m_dpc + 32'd4);
        check("d_exc",     {27'd0, d_exc},   {27'd0, m_exc});
        check("d_bd",      {31'd0, d_bd},    {31'd0, m_bd});
        check("d_valid",   {31'd0, d_valid}, {31'd0, m_valid});
    endtask

    task automatic cycle(input logic r, input logic st, input logic rd,
                         input logic bj, input logic [31:0] n);
        reset = r; stall = st; redirect = rd; d_is_bj = bj; npc = n;
        @(posedge clk);
        model_step(r, st, rd, bj, n);
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; d_is_bj = 1'b0; npc = '0;
        m_pc = 'x; m_instr = 'x; m_dpc = 'x; m_exc = 'x; m_bd = 'x; m_valid = 'x;

        // Reset state
        cycle(1, 0, 0, 0, 32'h0);
        check("rst_f_pc", f_pc, 32'h3000);
        check("rst_d_pc4", d_pc4, 32'h3004);
        check("rst_valid", {31'd0, d_valid}, 32'd0);

        // Free-running fetch
        cycle(0, 0, 0, 0, m_pc + 4);
        check("free_f_pc", f_pc, 32'h3004);
        check("free_d_instr", d_instr, 32'h2408_0001);
        check("free_valid", {31'd0, d_valid}, 32'd1);
        cycle(0, 0, 0, 0, m_pc + 4);
        check("free_d_pc", d_pc, 32'h3004);

        // Stall two cycles at 3008, then release
        cycle(0, 1, 0, 0, 32'hDEAD_BEEC);
        cycle(0, 1, 0, 0, 32'hDEAD_BEEC);
        check("stall_f_pc", f_pc, 32'h3008);
        check("stall_d_pc", d_pc, 32'h3004);
        cycle(0, 0, 0, 0, m_pc + 4);
        check("resume_d_pc", d_pc, 32'h3008);

        // Branch in D while fetching 300C
        cycle(0, 0, 0, 1, m_pc + 4);
        check("bd_set_pc", d_pc, 32'h300C);
        check("bd_set", {31'd0, d_bd}, 32'd1);
        cycle(0, 0, 0, 0, 32'h3002);
        check("bd_clr", {31'd0, d_bd}, 32'd0);

        // Misaligned then out-of-range fetch addresses
        check("bad_addr", imem_addr, 32'h3002);
        cycle(0, 0, 0, 0, 32'h7000);
        check("adel_mis", {27'd0, d_exc}, 32'd4);
        check("adel_mis_instr", d_instr, 32'h0);
        cycle(0, 0, 0, 0, 32'h3010);
        check("adel_hi", {27'd0, d_exc}, 32'd4);

        // Redirect beats stall
        cycle(0, 1, 1, 1, 32'h4180);
        check("redir_pc", f_pc, 32'h4180);
        check("redir_d_pc", d_pc, 32'h4180);
        check("redir_valid", {31'd0, d_valid}, 32'd0);

        // Redirect discards a bad fetch
        cycle(0, 0, 1, 0, 32'h3001);
        cycle(0, 0, 1, 0, 32'h5000);
        check("redir_bad_exc", {27'd0, d_exc}, 32'd0);

        // PC wrap
        cycle(0, 0, 0, 0, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 32'h3000);
        check("wrap_pc4", d_pc4, 32'h0);
        check("wrap_exc", {27'd0, d_exc}, 32'd4);

        // Reset overrides stall and redirect at PC 5000
        cycle(0, 0, 1, 0, 32'h5000);
        cycle(1, 1, 1, 1, 32'h4444);
        check("rst2_f_pc", f_pc, 32'h3000);
        check("rst2_d_pc", d_pc, 32'h3000);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] n;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel < 6)      n = m_pc + 4;
            else if (sel < 8) n = 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
            else if (sel < 9) n = $urandom;
            else              n = 32'hFFFF_FFFC;
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
